// File: rtl/cga_line_doubler.sv
// Scan doubler for the CGA pixel stream. Each input line is captured into one
// half of a ping-pong buffer. Meanwhile the previous line is replayed twice at
// the full clock rate, with a sync pulse at the start of each replay pass.
module cga_line_doubler #(
    parameter int DEPTH       = 1024,
    parameter int HSYNC_WIDTH = 108
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic       line_reset,
    input  logic [3:0] video,
    output logic [3:0] dbl_video,
    output logic       dbl_hsync,
    output logic       dbl_ce,
    output logic       overflow
);
    localparam int DATA_W = 4;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW     = $clog2(HSYNC_WIDTH + 1);

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [CW-1:0] HSYNC_W  = CW'(HSYNC_WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, PASS1, PASS2} state_t;

    logic [DATA_W-1:0] mem [2][DEPTH];

    logic              wr_bank;
    logic [AW:0]       wr_addr;
    logic              rd_bank;
    logic [AW:0]       line_len;
    logic              primed;
    logic [AW-1:0]     rd_addr;
    logic [CW-1:0]     pass_cnt;
    state_t            state;
    state_t            state_next;

    logic              in_pass;
    logic              pass_last;
    logic              wr_en;
    logic              wr_sel_bank;
    logic [AW-1:0]     wr_index;

    logic [DATA_W-1:0] rd_data_p0;
    logic              vld_p0;
    logic              hsync_p0;

    assign in_pass   = (state == PASS1) || (state == PASS2);
    assign pass_last = ({1'b0, rd_addr} == (line_len - LEN_ONE));

    // Write port steering: a pixel coincident with line_reset opens the new line.
    always_comb begin
        wr_en       = 1'b0;
        wr_sel_bank = wr_bank;
        wr_index    = wr_addr[AW-1:0];
        if (pix_ce) begin
            if (line_reset) begin
                wr_en       = 1'b1;
                wr_sel_bank = ~wr_bank;
                wr_index    = '0;
            end else if (wr_addr < DEPTH_W) begin
                wr_en = 1'b1;
            end
        end
    end

    // Line buffer write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_sel_bank][wr_index] <= video;
        end
    end

    // Capture bookkeeping: bank swap, line length latch, overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank  <= 1'b0;
            wr_addr  <= '0;
            rd_bank  <= 1'b0;
            line_len <= '0;
            primed   <= 1'b0;
            overflow <= 1'b0;
        end else if (line_reset) begin
            line_len <= wr_addr;
            rd_bank  <= wr_bank;
            wr_bank  <= ~wr_bank;
            wr_addr  <= pix_ce ? LEN_ONE : '0;
            primed   <= 1'b1;
        end else if (pix_ce) begin
            if (wr_addr < DEPTH_W) begin
                wr_addr <= wr_addr + LEN_ONE;
            end else begin
                overflow <= 1'b1;
            end
        end
    end

    // Playback state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Playback next state; line_reset overrides whatever pass is running.
    always_comb begin
        state_next = state;
        case (state)
            PASS1:   if (pass_last) state_next = PASS2;
            PASS2:   if (pass_last) state_next = IDLE;
            default: state_next = state;
        endcase
        if (line_reset) begin
            state_next = (primed && (wr_addr != '0)) ? PASS1 : IDLE;
        end
    end

    // Read address and per-pass cycle counter (saturating, drives sync width).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr  <= '0;
            pass_cnt <= '0;
        end else if (line_reset) begin
            rd_addr  <= '0;
            pass_cnt <= '0;
        end else if (in_pass) begin
            if (pass_last) begin
                rd_addr  <= '0;
                pass_cnt <= '0;
            end else begin
                rd_addr <= rd_addr + ADDR_ONE;
                if (pass_cnt < HSYNC_W) begin
                    pass_cnt <= pass_cnt + CNT_ONE;
                end
            end
        end
    end

    // Stage p0: synchronous RAM read, no reset on the data word.
    always_ff @(posedge clk) begin
        rd_data_p0 <= mem[rd_bank][rd_addr];
    end

    // Stage p0: valid and sync travel with the read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0   <= 1'b0;
            hsync_p0 <= 1'b0;
        end else begin
            vld_p0   <= in_pass;
            hsync_p0 <= in_pass && (pass_cnt < HSYNC_W);
        end
    end

    // Stage p1: output registers, blanked to zero when no pixel is carried.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbl_video <= '0;
            dbl_hsync <= 1'b0;
            dbl_ce    <= 1'b0;
        end else begin
            dbl_video <= vld_p0 ? rd_data_p0 : '0;
            dbl_hsync <= hsync_p0;
            dbl_ce    <= vld_p0;
        end
    end
endmodule
